// File: rtl/modulo_unit.sv
// Iterative unsigned remainder engine: restoring division, one quotient bit per clock.
// Optional macro MODULO_EARLY_EXIT_EN: skips the iterations when the divisor is 0 or the dividend is below it.
module modulo_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             modulo_start_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic [WIDTH-1:0] res_o,
    output logic             modulo_ready_o,
    output logic             busy_o,
    output logic             div_by_zero_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH:0]   rem_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH:0]   rem_nxt;
    logic             accept;
    logic             last_iter;
`ifdef MODULO_EARLY_EXIT_EN
    logic             early_exit;
`endif

    // One restoring step: shift in the next dividend bit, subtract the divisor if it fits.
    function automatic logic [WIDTH:0] restore_step(
        input logic [WIDTH:0]   rem,
        input logic             msb,
        input logic [WIDTH-1:0] div
    );
        logic [WIDTH:0] t;
        t = (rem << 1) | {{WIDTH{1'b0}}, msb};
        if (t >= {1'b0, div}) begin
            return t - {1'b0, div};
        end
        return t;
    endfunction

    assign rem_nxt   = restore_step(rem_r, a_r[WIDTH-1], b_r);
    assign last_iter = (cnt_r == CNT_W'(WIDTH - 1));
`ifdef MODULO_EARLY_EXIT_EN
    assign early_exit = (op_b_i == '0) || (op_a_i < op_b_i);
`endif

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        accept    = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (modulo_start_i) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
`ifdef MODULO_EARLY_EXIT_EN
                    if (early_exit) begin
                        state_nxt = DONE;
                    end
`endif
                end else if (state_r == DONE) begin
                    state_nxt = IDLE;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // res_o keeps the previous result until the new remainder lands at the end of CALC.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            a_r           <= '0;
            b_r           <= '0;
            rem_r         <= '0;
            cnt_r         <= '0;
            res_o         <= '0;
            div_by_zero_o <= 1'b0;
        end else if (accept) begin
            a_r           <= op_a_i;
            b_r           <= op_b_i;
            rem_r         <= '0;
            cnt_r         <= '0;
            div_by_zero_o <= 1'b0;
`ifdef MODULO_EARLY_EXIT_EN
            if (early_exit) begin
                res_o         <= op_a_i;
                div_by_zero_o <= (op_b_i == '0);
            end
`endif
        end else if (state_r == CALC) begin
            a_r   <= a_r << 1;
            rem_r <= rem_nxt;
            cnt_r <= cnt_r + CNT_W'(1);
            if (last_iter) begin
                res_o         <= rem_nxt[WIDTH-1:0];
                div_by_zero_o <= (b_r == '0);
            end
        end
    end

    assign busy_o         = (state_r == CALC);
    assign modulo_ready_o = (state_r == DONE);

endmodule

// File: tb/tb_modulo_unit.sv
// Directed-vector and randomized bench for modulo_unit (WIDTH=16).
module tb_modulo_unit;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             modulo_start_i = 1'b0;
    logic [WIDTH-1:0] op_a_i = '0;
    logic [WIDTH-1:0] op_b_i = '0;
    logic [WIDTH-1:0] res_o;
    logic             modulo_ready_o;
    logic             busy_o;
    logic             div_by_zero_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] r;
        logic             z;
    } vec_t;

    modulo_unit #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst_i          (rst_i),
        .modulo_start_i (modulo_start_i),
        .op_a_i         (op_a_i),
        .op_b_i         (op_b_i),
        .res_o          (res_o),
        .modulo_ready_o (modulo_ready_o),
        .busy_o         (busy_o),
        .div_by_zero_o  (div_by_zero_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Negedges counted from the accept edge until ready is first seen:
    // ready rises on the 16th edge after accept, i.e. visible on the 17th negedge.
    function automatic int exp_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef MODULO_EARLY_EXIT_EN
        if (b == '0 || a < b) return 1;
`endif
        return WIDTH + 1;
    endfunction

    // Called just after a negedge; on return we sit at the negedge where ready is high.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int poke_at,
                         output logic [WIDTH-1:0] r, output logic z, output int lat,
                         output logic busy_ok);
        bit seen;
        modulo_start_i = 1'b1;
        op_a_i = a;
        op_b_i = b;
        @(posedge clk);
        lat = 0;
        busy_ok = 1'b1;
        seen = 1'b0;
        r = '0;
        z = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == poke_at) begin
                modulo_start_i = 1'b1;
                op_a_i = 16'd100;
                op_b_i = 16'd3;
            end else begin
                modulo_start_i = 1'b0;
                op_a_i = ~a;
                op_b_i = ~b;
            end
            if (modulo_ready_o) begin
                seen = 1'b1;
                if (busy_o) busy_ok = 1'b0;
                r = res_o;
                z = div_by_zero_o;
            end else if (!busy_o) begin
                busy_ok = 1'b0;
            end
        end
        if (!seen) lat = 99;
    endtask

    task automatic check_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] er, input logic ez, input int poke_at);
        logic [WIDTH-1:0] r;
        logic             z;
        int               lat;
        logic             bok;
        do_op(a, b, poke_at, r, z, lat, bok);
        check({tag, " res"}, r, er);
        check({tag, " div_by_zero"}, z, ez);
        check({tag, " latency"}, lat, exp_lat(a, b));
        check({tag, " busy"}, bok, 1'b1);
    endtask

    task automatic check_drop(input string tag, input logic [WIDTH-1:0] er);
        @(negedge clk);
        check({tag, " ready width"}, modulo_ready_o, 1'b0);
        check({tag, " res held"}, res_o, er);
    endtask

    initial begin
        vec_t tbl[10];
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] r;
        logic             z;
        int               lat;
        logic             bok;
        int               ready_cnt;
        int               busy_cnt;

        tbl[0] = '{a: 16'd48,    b: 16'd18,    r: 16'd12,    z: 1'b0};
        tbl[1] = '{a: 16'd65535, b: 16'd1,     r: 16'd0,     z: 1'b0};
        tbl[2] = '{a: 16'd1000,  b: 16'd7,     r: 16'd6,     z: 1'b0};
        tbl[3] = '{a: 16'd0,     b: 16'd5,     r: 16'd0,     z: 1'b0};
        tbl[4] = '{a: 16'd65535, b: 16'd65535, r: 16'd0,     z: 1'b0};
        tbl[5] = '{a: 16'd65535, b: 16'd0,     r: 16'd65535, z: 1'b1};
        tbl[6] = '{a: 16'd1,     b: 16'd65535, r: 16'd1,     z: 1'b0};
        tbl[7] = '{a: 16'd12345, b: 16'd123,   r: 16'd45,    z: 1'b0};
        tbl[8] = '{a: 16'd65534, b: 16'd65535, r: 16'd65534, z: 1'b0};
        tbl[9] = '{a: 16'd40000, b: 16'd3,     r: 16'd1,     z: 1'b0};

        #1;
        check("reset res", res_o, 16'd0);
        check("reset ready", modulo_ready_o, 1'b0);
        check("reset busy", busy_o, 1'b0);
        check("reset dbz", div_by_zero_o, 1'b0);
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            check_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].z, -1);
            check_drop($sformatf("vec%0d", i), tbl[i].r);
        end

        // Back-to-back: second start held during the DONE cycle of the first op.
        check_op("b2b first", 16'd65535, 16'd1, 16'd0, 1'b0, -1);
        check_op("b2b second", 16'd1000, 16'd7, 16'd6, 1'b0, -1);
        check_drop("b2b", 16'd6);

        // Start pulse with new operands mid-CALC must be ignored.
        check_op("ignore start", 16'd5, 16'd9, 16'd5, 1'b0, 5);
        check_drop("ignore start", 16'd5);

        check_op("div0", 16'd7, 16'd0, 16'd7, 1'b1, -1);
        check_drop("div0", 16'd7);

        // Asynchronous reset in the middle of iteration 8.
        modulo_start_i = 1'b1;
        op_a_i = 16'd300;
        op_b_i = 16'd17;
        @(posedge clk);
        @(negedge clk);
        modulo_start_i = 1'b0;
        check("pre-reset busy", busy_o, 1'b1);
        repeat (7) @(posedge clk);
        #2 rst_i = 1'b1;
        #1;
        check("mid reset res", res_o, 16'd0);
        check("mid reset ready", modulo_ready_o, 1'b0);
        check("mid reset busy", busy_o, 1'b0);
        check("mid reset dbz", div_by_zero_o, 1'b0);
        @(negedge clk);
        rst_i = 1'b0;
        ready_cnt = 0;
        busy_cnt = 0;
        repeat (24) begin
            @(negedge clk);
            if (modulo_ready_o) ready_cnt++;
            if (busy_o) busy_cnt++;
        end
        check("lost op ready", ready_cnt, 0);
        check("lost op busy", busy_cnt, 0);
        check_op("after reset", 16'd300, 16'd17, 16'd11, 1'b0, -1);
        check_drop("after reset", 16'd11);

        for (int k = 0; k < 1000; k++) begin
            a = 16'($urandom);
            b = (k % 4 == 0) ? 16'($urandom_range(1, 20)) : 16'($urandom_range(1, 65535));
            do_op(a, b, -1, r, z, lat, bok);
            check("rand res", r, a % b);
            check("rand latency", lat, exp_lat(a, b));
            check("rand busy", bok, 1'b1);
        end
        check_drop("rand last", r);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
